matrix_scan_capture: RTL and testbench
======================================

// Module: matrix_scan_capture
// PURPOSE
//  Receive-side counterpart of the 8x8 LED matrix scan driver. Samples the one-hot row strobe and
//  column data bus and rebuilds the displayed image into a published frame buffer. Checks scan
//  ordering and reports complete frames, content changes and sequence errors. Used as an on-chip
//  display monitor and as the scoreboard front end in display testbenches.
// PARAMETERS
//  ROWS         8   rows per frame; row strobe width, one-hot
//  COLS         8   column bus width
//  FRAME_CNT_W  16  width of completed-frame counter (wraps)
//  ERR_CNT_W    8   width of sequence-error counter (saturates)
// PORTS
//  clk            in   1            system clock, all logic on rising edge
//  rst            in   1            synchronous, active-high reset
//  scan_valid     in   1            row/column sampled only on cycles where high
//  row            in   ROWS         one-hot row strobe; bit 0 = first row of a frame
//  column         in   COLS         column data for the strobed row
//  rd_row         in   clog2(ROWS)  read-port row index
//  rd_column      out  COLS         published frame row rd_row, 1-cycle registered latency
//  frame_flat     out  ROWS*COLS    published frame, row r at bits [r*COLS +: COLS]
//  frame_done     out  1            1-cycle pulse: new frame published
//  frame_changed  out  1            1-cycle pulse with frame_done when new frame != previous
//  seq_err        out  1            1-cycle pulse: ordering/one-hot violation detected
//  locked         out  1            high while in CAPTURE
//  frame_count    out  FRAME_CNT_W  completed frames since reset, wraps to 0
//  err_count      out  ERR_CNT_W    sequence errors since reset, saturates at all-ones
// BEHAVIOUR
//  Reset: every output 0, published frame and shadow buffer all 0, state HUNT, idx 0.
//  scan_valid low: no state, buffer or counter change; pulses deassert.
//  States (expected index idx in 0..ROWS-1):
//   HUNT: valid row==1<<0 -> shadow[0]<=column, idx<=1, go CAPTURE. Any other valid row -> stay,
//         no error flagged (normal acquisition).
//   CAPTURE: valid row==1<<idx -> shadow[idx]<=column; idx<=idx+1.
//     idx==ROWS-1 -> publish shadow (with this column) to frame, idx<=0, stay CAPTURE.
//     valid row==1<<0 while idx!=0 -> seq_err; shadow[0]<=column, idx<=1 (restart frame).
//     valid row zero, not one-hot, or other wrong index -> seq_err, go HUNT, idx<=0.
//  Publish: frame_flat updates and frame_done pulses on the cycle after the last-row sample.
//   frame_changed = new frame != previously published (first frame compared against all 0).
//   frame_count increments by 1 per publish, wraps at 2^FRAME_CNT_W.
//  Partial frames are never published. The published frame holds its value until the next publish.
//  seq_err registered: pulses the cycle after the offending sample. err_count += 1 unless saturated.
//  rd_column <= frame row rd_row each cycle. Index >= ROWS returns 0. A publish and a read in the
//   same cycle return the old row.
//  locked = (state==CAPTURE), registered.
//  rst mid-frame: shadow and frame cleared, counters 0, HUNT; the next frame needs a fresh row-0 start.
// TESTING
//  1 rst; valid rows 01..80 with cols 1C,1C,08,3E,2A,08,14,22 -> frame_done and frame_changed
//    pulse 1 cycle after row 80; frame_count=1; rd_row=3 -> rd_column=3E next cycle.
//  2 Repeat identical frame -> frame_done=1, frame_changed=0, frame_count=2; then a frame with
//    row 2 col=90 -> frame_changed=1.
//  3 Start mid-scan at row 10 (HUNT) -> no seq_err, locked=0 until row 01; first frame_done
//    only after a full 01..80 sequence.
//  4 In CAPTURE, send row 04 when 02 expected -> seq_err pulse, err_count=1, locked=0, no
//    publish; send row 03 -> seq_err, err_count=2.
//  5 scan_valid low for 5 cycles mid-frame with garbage row/column -> ignored; frame completes
//    normally. Also drive 300 errors -> err_count=FF, holds.
//  6 Assert rst after row 08 of frame 2 -> all outputs 0 next cycle; the next full frame
//    publishes with frame_count=1.

Source files
------------

// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture
//   Receive-side monitor for an 8x8 LED matrix scan. Samples the one-hot row
//   strobe and column bus, rebuilds each scanned frame in a shadow buffer and
//   publishes it only when every row has arrived in order. It reports
//   published frames, content changes and scan-ordering errors.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_scan_valid      row/column are sampled only when high
//   i_row             one-hot row strobe, bit 0 is the first row of a frame
//   i_column          column data for the strobed row
//   i_rd_row          read-port row index
//   o_rd_column       published row i_rd_row, one cycle of latency
//   o_frame_flat      published frame, row r at [r*COLS +: COLS]
//   o_frame_done      pulse: a new frame was published
//   o_frame_changed   pulse with o_frame_done when the frame content differs
//   o_seq_err         pulse: ordering or one-hot violation seen
//   o_locked          high while capturing in step with the scan
//   o_frame_count     published frames since reset (wraps)
//   o_err_count       sequence errors since reset (saturates)
module matrix_scan_capture #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int FRAME_CNT_W = 16,
  parameter int ERR_CNT_W   = 8,
  localparam int IDX_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_scan_valid,
  input  logic [ROWS-1:0]        i_row,
  input  logic [COLS-1:0]        i_column,
  input  logic [IDX_W-1:0]       i_rd_row,
  output logic [COLS-1:0]        o_rd_column,
  output logic [ROWS*COLS-1:0]   o_frame_flat,
  output logic                   o_frame_done,
  output logic                   o_frame_changed,
  output logic                   o_seq_err,
  output logic                   o_locked,
  output logic [FRAME_CNT_W-1:0] o_frame_count,
  output logic [ERR_CNT_W-1:0]   o_err_count
);

  typedef enum logic {S_HUNT = 1'b0, S_CAPTURE = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt, w_load_idx;
  logic [COLS-1:0]        r_shadow [ROWS];
  logic [COLS-1:0]        r_frame  [ROWS];
  logic [COLS-1:0]        r_rd_column;
  logic                   r_frame_done, r_frame_changed, r_seq_err;
  logic [FRAME_CNT_W-1:0] r_frame_count;
  logic [ERR_CNT_W-1:0]   r_err_count;

  logic                   w_hit, w_row0, w_last;
  logic                   w_load, w_publish, w_err;
  logic [ROWS-1:0]        w_expect;
  logic [ROWS*COLS-1:0]   w_frame_flat, w_new_flat;
  logic [31:0]            w_rd_sel;

  assign w_expect = ROWS'(1) << r_idx;
  assign w_hit    = (i_row == w_expect);
  assign w_row0   = (i_row == ROWS'(1));
  assign w_last   = (r_idx == IDX_W'(ROWS - 1));
  assign w_rd_sel = 32'(i_rd_row);

  // The frame being published is the shadow rows plus the column arriving
  // with the last-row strobe, so it can be compared before it is stored.
  for (genvar g = 0; g < ROWS; g++) begin : g_flat
    assign w_frame_flat[g*COLS +: COLS] = r_frame[g];
    if (g == ROWS - 1) begin : g_last
      assign w_new_flat[g*COLS +: COLS] = i_column;
    end else begin : g_mid
      assign w_new_flat[g*COLS +: COLS] = r_shadow[g];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_HUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_scan_valid) begin
      case (r_state)
        S_HUNT:    if (w_row0) w_state_nxt = S_CAPTURE;
        S_CAPTURE: if (!w_hit && !w_row0) w_state_nxt = S_HUNT;
        default:   w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_comb begin
    w_load     = 1'b0;
    w_load_idx = '0;
    w_publish  = 1'b0;
    w_err      = 1'b0;
    w_idx_nxt  = r_idx;
    if (i_scan_valid) begin
      case (r_state)
        S_HUNT: begin
          // Rows other than row 0 are normal while acquiring; not errors.
          if (w_row0) begin
            w_load    = 1'b1;
            w_idx_nxt = IDX_W'(1);
          end
        end
        S_CAPTURE: begin
          if (w_hit) begin
            w_load     = 1'b1;
            w_load_idx = r_idx;
            if (w_last) begin
              w_publish = 1'b1;
              w_idx_nxt = '0;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else if (w_row0) begin
            // Early row 0: the scan restarted, keep lock and begin anew.
            w_err     = 1'b1;
            w_load    = 1'b1;
            w_idx_nxt = IDX_W'(1);
          end else begin
            w_err     = 1'b1;
            w_idx_nxt = '0;
          end
        end
        default: w_idx_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx           <= '0;
      r_frame_done    <= 1'b0;
      r_frame_changed <= 1'b0;
      r_seq_err       <= 1'b0;
      r_frame_count   <= '0;
      r_err_count     <= '0;
      r_rd_column     <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_shadow[r] <= '0;
        r_frame[r]  <= '0;
      end
    end else begin
      r_idx           <= w_idx_nxt;
      r_frame_done    <= w_publish;
      r_frame_changed <= w_publish && (w_new_flat != w_frame_flat);
      r_seq_err       <= w_err;
      if (w_load) r_shadow[w_load_idx] <= i_column;
      if (w_publish) begin
        for (int r = 0; r < ROWS; r++) r_frame[r] <= w_new_flat[r*COLS +: COLS];
        r_frame_count <= r_frame_count + 1'b1;
      end
      if (w_err && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
      // Reads the pre-publish frame when a publish lands in the same cycle.
      r_rd_column <= (w_rd_sel < ROWS) ? r_frame[i_rd_row] : '0;
    end
  end

  assign o_rd_column     = r_rd_column;
  assign o_frame_flat    = w_frame_flat;
  assign o_frame_done    = r_frame_done;
  assign o_frame_changed = r_frame_changed;
  assign o_seq_err       = r_seq_err;
  assign o_locked        = (r_state == S_CAPTURE);
  assign o_frame_count   = r_frame_count;
  assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Testbench for matrix_scan_capture: table of scan steps with expected
// pulses/counters, plus a queue of expected published frames.
module tb_matrix_scan_capture;

  localparam logic [63:0] FA = 64'h2214082A3E081C1C;
  localparam logic [63:0] FB = 64'h2214082A3E901C1C;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_valid;
  logic [7:0]  row_i;
  logic [7:0]  col_i;
  logic [2:0]  rd_row;
  logic [7:0]  rd_column;
  logic [63:0] frame_flat;
  logic        frame_done, frame_changed, seq_err, locked;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  matrix_scan_capture dut (
    .i_clk(clk), .i_rst(rst), .i_scan_valid(scan_valid), .i_row(row_i),
    .i_column(col_i), .i_rd_row(rd_row), .o_rd_column(rd_column),
    .o_frame_flat(frame_flat), .o_frame_done(frame_done),
    .o_frame_changed(frame_changed), .o_seq_err(seq_err), .o_locked(locked),
    .o_frame_count(frame_count), .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        done, chg, err, lock;
    logic [15:0] fc;
    logic [7:0]  ec;
    logic [63:0] pub;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cur_id = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL step%0d %s: got %h expected %h", cur_id, nm, act, exp);
  endtask

  task automatic step(input logic v, input logic [7:0] r, input logic [7:0] c,
                      input logic d, input logic ch, input logic e, input logic l,
                      input logic [15:0] fc, input logic [7:0] ec, input logic [63:0] pub);
    logic [63:0] exp_f;
    @(negedge clk);
    scan_valid = v; row_i = r; col_i = c;
    if (d) sb.push_back(pub);
    @(posedge clk); #1;
    cur_id++;
    check("frame_done", 64'(frame_done), 64'(d));
    check("frame_changed", 64'(frame_changed), 64'(ch));
    check("seq_err", 64'(seq_err), 64'(e));
    check("locked", 64'(locked), 64'(l));
    check("frame_count", 64'(frame_count), 64'(fc));
    check("err_count", 64'(err_count), 64'(ec));
    if (frame_done) begin
      if (sb.size() == 0) check("unexpected_publish", 64'(frame_done), 64'd0);
      else begin
        exp_f = sb.pop_front();
        check("frame_flat", frame_flat, exp_f);
      end
    end
  endtask

  task automatic add(input logic v, input logic [7:0] r, input logic [7:0] c,
                     input logic d, input logic ch, input logic e, input logic l,
                     input logic [15:0] fc, input logic [7:0] ec, input logic [63:0] pub);
    vecs.push_back('{v, r, c, d, ch, e, l, fc, ec, pub});
  endtask

  // Rows first..7 of img in order, starting from an idle/locked-at-row-0 state.
  task automatic add_frame(input logic [63:0] img, input int first, input logic ch,
                           input logic [15:0] fc, input logic [7:0] ec);
    for (int r = first; r < 8; r++)
      add(1'b1, 8'(1 << r), img[r*8 +: 8], r == 7, (r == 7) ? ch : 1'b0, 1'b0, 1'b1,
          (r == 7) ? fc + 16'd1 : fc, ec, img);
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].v, vecs[i].row, vecs[i].col, vecs[i].done, vecs[i].chg,
           vecs[i].err, vecs[i].lock, vecs[i].fc, vecs[i].ec, vecs[i].pub);
    vecs.delete();
  endtask

  task automatic check_all_zero();
    check("rst_rd_column", 64'(rd_column), 64'd0);
    check("rst_frame_flat", frame_flat, 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_changed", 64'(frame_changed), 64'd0);
    check("rst_seq_err", 64'(seq_err), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
  endtask

  initial begin
    logic [7:0] ec;
    rst = 1'b1; scan_valid = 1'b0; row_i = 8'h00; col_i = 8'h00; rd_row = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    @(negedge clk); rst = 1'b0;

    // Frames A, A (unchanged), B (row 2 differs)
    add_frame(FA, 0, 1'b1, 16'd0, 8'd0);
    add_frame(FA, 0, 1'b0, 16'd1, 8'd0);
    add_frame(FB, 0, 1'b1, 16'd2, 8'd0);
    // Out-of-order row, then non-one-hot row
    add(1, 8'h01, 8'h1C, 0, 0, 0, 1, 16'd3, 8'd0, 64'd0);
    add(1, 8'h04, 8'h08, 0, 0, 1, 0, 16'd3, 8'd1, 64'd0);
    add(1, 8'h01, 8'h1C, 0, 0, 0, 1, 16'd3, 8'd1, 64'd0);
    add(1, 8'h03, 8'h08, 0, 0, 1, 0, 16'd3, 8'd2, 64'd0);
    // Mid-scan entry while hunting: silent until row 0
    add(1, 8'h10, 8'h2A, 0, 0, 0, 0, 16'd3, 8'd2, 64'd0);
    add(1, 8'h20, 8'h08, 0, 0, 0, 0, 16'd3, 8'd2, 64'd0);
    add(1, 8'h40, 8'h14, 0, 0, 0, 0, 16'd3, 8'd2, 64'd0);
    add(1, 8'h80, 8'h22, 0, 0, 0, 0, 16'd3, 8'd2, 64'd0);
    add_frame(FA, 0, 1'b1, 16'd3, 8'd2);
    // Early row 0 restarts the frame; first row-0 data is discarded
    add(1, 8'h01, 8'h55, 0, 0, 0, 1, 16'd4, 8'd2, 64'd0);
    add(1, 8'h02, 8'h1C, 0, 0, 0, 1, 16'd4, 8'd2, 64'd0);
    add(1, 8'h01, 8'h1C, 0, 0, 1, 1, 16'd4, 8'd3, 64'd0);
    add_frame(FA, 1, 1'b0, 16'd4, 8'd3);
    // Invalid cycles with garbage mid-frame
    add(1, 8'h01, 8'h1C, 0, 0, 0, 1, 16'd5, 8'd3, 64'd0);
    add(1, 8'h02, 8'h1C, 0, 0, 0, 1, 16'd5, 8'd3, 64'd0);
    for (int i = 0; i < 5; i++) add(0, 8'h80, 8'hFF, 0, 0, 0, 1, 16'd5, 8'd3, 64'd0);
    add_frame(FB, 2, 1'b1, 16'd5, 8'd3);
    add(0, 8'h01, 8'h00, 0, 0, 0, 1, 16'd6, 8'd3, 64'd0);
    run_table();

    // Read port
    rd_row = 3'd3;
    step(0, 8'h00, 8'h00, 0, 0, 0, 1, 16'd6, 8'd3, 64'd0);
    check("rd_row3", 64'(rd_column), 64'h3E);
    rd_row = 3'd2;
    step(0, 8'h00, 8'h00, 0, 0, 0, 1, 16'd6, 8'd3, 64'd0);
    check("rd_row2", 64'(rd_column), 64'h90);
    add_frame(FA, 0, 1'b1, 16'd6, 8'd3);
    run_table();
    check("rd_same_cycle_old", 64'(rd_column), 64'h90);
    step(0, 8'h00, 8'h00, 0, 0, 0, 1, 16'd7, 8'd3, 64'd0);
    check("rd_after_publish", 64'(rd_column), 64'h08);
    rd_row = 3'd7;
    step(0, 8'h00, 8'h00, 0, 0, 0, 1, 16'd7, 8'd3, 64'd0);
    check("rd_row7", 64'(rd_column), 64'h22);

    // Error counter saturation
    ec = 8'd3;
    for (int i = 0; i < 300; i++) begin
      step(1, 8'h01, 8'h1C, 0, 0, 0, 1, 16'd7, ec, 64'd0);
      if (ec != 8'hFF) ec = ec + 8'd1;
      step(1, 8'h04, 8'h08, 0, 0, 1, 0, 16'd7, ec, 64'd0);
    end
    check("err_saturated", 64'(err_count), 64'hFF);

    // Reset in the middle of frame 2
    @(negedge clk); rst = 1'b1; scan_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    add_frame(FA, 0, 1'b1, 16'd0, 8'd0);
    for (int r = 0; r < 4; r++) add(1, 8'(1 << r), FB[r*8 +: 8], 0, 0, 0, 1, 16'd1, 8'd0, 64'd0);
    run_table();
    @(negedge clk); rst = 1'b1; scan_valid = 1'b1; row_i = 8'h10; col_i = 8'h2A;
    @(posedge clk); #1;
    cur_id++;
    check_all_zero();
    @(negedge clk); rst = 1'b0;
    for (int r = 4; r < 8; r++) add(1, 8'(1 << r), FB[r*8 +: 8], 0, 0, 0, 0, 16'd0, 8'd0, 64'd0);
    add_frame(FB, 0, 1'b1, 16'd0, 8'd0);
    run_table();

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
